// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   - Loader state encoding.
//   - Default memory geometry (64 words, 6-bit word address).
//   - Number of byte lanes per instruction word.
package imem_loader_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 64;
    localparam int DEFAULT_ADDR_W      = 6;
    localparam int BYTE_LANES          = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between the boot byte source / instruction memory and the loader.
//   in_valid, in_byte, in_ready : byte stream (valid/ready, accepted when both high)
//   wr_en, wr_addr, wr_data     : instruction memory write port
// modport slave  : the loader side (consumes the stream, drives the write port)
// modport master : the environment side (drives the stream, observes the write port)
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_byte,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart at lane 0 (start of a new load)
//   byte_en    : byte_in is consumed this cycle
//   byte_in    : incoming byte
//   byte_idx   : lane the next consumed byte will fill (0..3)
//   word_valid : registered one-cycle pulse, high the cycle after the 4th byte
//   word       : assembled word, held until the next word completes
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_idx,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx_reg;
    logic [31:0] lanes_reg;
    logic [31:0] lanes_next;
    logic [31:0] word_reg;
    logic        word_valid_reg;

    // Each lane takes the incoming byte only when it is the current lane;
    // the 4th byte goes straight into the completed word without waiting a cycle.
    genvar gi;
    generate
        for (gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
            assign lanes_next[gi*8 +: 8] = (byte_idx_reg == 2'(gi)) ? byte_in
                                                                     : lanes_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx_reg   <= '0;
            lanes_reg      <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= 1'b0;
            if (clear) begin
                byte_idx_reg <= '0;
                lanes_reg    <= '0;
            end else if (byte_en) begin
                lanes_reg    <= lanes_next;
                byte_idx_reg <= byte_idx_reg + 2'd1;
                if (byte_idx_reg == 2'(BYTE_LANES - 1)) begin
                    word_reg       <= lanes_next;
                    word_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign byte_idx   = byte_idx_reg;
    assign word_valid = word_valid_reg;
    assign word       = word_reg;

endmodule

// File: rtl/imem_loader.sv
// Boot-time writer for the core's instruction memory.
// Stream format: count byte N (1..DEPTH_WORDS), 4N little-endian payload bytes,
// then one byte equal to the XOR of all payload bytes. The core is held in reset
// until a load finishes with a matching checksum.
//   clk, reset : clock and synchronous active-high reset
//   bus        : byte stream in, instruction memory write port out (slave modport)
//   reload     : one-cycle pulse, restarts from DONE or ERROR
//   core_reset : high everywhere except DONE
//   done       : load completed with a good checksum
//   err        : load aborted (bad count or bad checksum)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int ADDR_W      = DEFAULT_ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    imem_loader_if.slave     bus,
    input  logic             reload,
    output logic             core_reset,
    output logic             done,
    output logic             err
);

    // One extra bit so that N = DEPTH_WORDS is representable without wrap.
    localparam int CNT_W = ADDR_W + 1;

    state_t            state_reg;
    logic              in_ready_reg;
    logic              core_reset_reg;
    logic              done_reg;
    logic              err_reg;
    logic [CNT_W-1:0]  n_reg;
    logic [CNT_W-1:0]  word_cnt_reg;
    logic [7:0]        csum_reg;
    logic [ADDR_W-1:0] wr_addr_reg;

    logic              accept;
    logic              count_ok;
    logic              word_done;
    logic              last_word;
    logic [1:0]        byte_idx;
    logic              word_valid;
    logic [31:0]       word;

    assign accept    = bus.in_valid && in_ready_reg;
    assign count_ok  = (bus.in_byte != 8'd0) && (32'(bus.in_byte) <= DEPTH_WORDS);
    assign word_done = accept && (state_reg == ST_DATA) && (byte_idx == 2'(BYTE_LANES - 1));
    assign last_word = (word_cnt_reg == n_reg - CNT_W'(1));

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept && (state_reg == ST_IDLE)),
        .byte_en    (accept && (state_reg == ST_DATA)),
        .byte_in    (bus.in_byte),
        .byte_idx   (byte_idx),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            in_ready_reg   <= 1'b1;
            core_reset_reg <= 1'b1;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            n_reg          <= '0;
            word_cnt_reg   <= '0;
            csum_reg       <= '0;
            wr_addr_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (!count_ok) begin
                            state_reg    <= ST_ERROR;
                            in_ready_reg <= 1'b0;
                            err_reg      <= 1'b1;
                        end else begin
                            n_reg        <= CNT_W'(bus.in_byte);
                            word_cnt_reg <= '0;
                            csum_reg     <= '0;
                            state_reg    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum_reg <= csum_reg ^ bus.in_byte;
                        if (word_done) begin
                            // Address is captured together with the assembler's
                            // word_valid so both appear in the same cycle.
                            wr_addr_reg  <= word_cnt_reg[ADDR_W-1:0];
                            word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                            if (last_word) begin
                                state_reg <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        if (bus.in_byte == csum_reg) begin
                            state_reg      <= ST_DONE;
                            done_reg       <= 1'b1;
                            core_reset_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_ERROR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (reload) begin
                        state_reg      <= ST_IDLE;
                        in_ready_reg   <= 1'b1;
                        core_reset_reg <= 1'b1;
                        done_reg       <= 1'b0;
                        err_reg        <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    in_ready_reg   <= 1'b1;
                    core_reset_reg <= 1'b1;
                    done_reg       <= 1'b0;
                    err_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_reg;
    assign bus.wr_en    = word_valid;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_data  = word;
    assign core_reset   = core_reset_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic load, full depth, bad checksum, illegal
// counts, gapped stream with DONE backpressure, reset mid-load and reload.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reload = 1'b0;
    logic core_reset, done, err;

    int checks = 0;
    int errors = 0;

    imem_loader_if #(.ADDR_W(6)) bus ();

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .reload     (reload),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Write-port log, one line per written word.
    int          wr_count = 0;
    logic [5:0]  log_addr [0:255];
    logic [31:0] log_data [0:255];

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            log_addr[wr_count[7:0]] = bus.wr_addr;
            log_data[wr_count[7:0]] = bus.wr_data;
            $display("WR #%0d addr=%0d data=%08h", wr_count, bus.wr_addr, bus.wr_data);
            wr_count++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one byte and return 1 time unit after the edge that consumed it.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            t++;
            if (t > 100) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    int base;
    int bad;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;

        // Reset state
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        // Basic load
        base = wr_count;
        send_byte(8'h01);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h50); send_byte(8'h00);
        chk("basic_wr_en_latency", 32'(bus.wr_en), 32'd1);
        chk("basic_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("basic_wr_data", bus.wr_data, 32'h00500513);
        chk("basic_done_early", 32'(done), 32'd0);
        send_byte(8'h46);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_core_reset", 32'(core_reset), 32'd0);
        chk("basic_in_ready", 32'(bus.in_ready), 32'd0);
        chk("basic_wr_count", 32'(wr_count - base), 32'd1);

        // DONE with in_valid held: nothing consumed, nothing written
        base = wr_count;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hAA;
        idle(6);
        chk("done_hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk("done_hold_done", 32'(done), 32'd1);
        chk("done_hold_writes", 32'(wr_count - base), 32'd0);
        bus.in_valid = 1'b0;
        pulse_reload();
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_core_reset", 32'(core_reset), 32'd1);
        chk("reload_in_ready", 32'(bus.in_ready), 32'd1);

        // Full depth: word i = i, XOR of all bytes 0..63 is 0
        base = wr_count;
        send_byte(8'h40);
        for (int i = 0; i < 64; i++) send_word(32'(i));
        send_byte(8'h00);
        chk("full_wr_count", 32'(wr_count - base), 32'd64);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (log_addr[base + i] !== 6'(i) || log_data[base + i] !== 32'(i)) bad++;
        end
        chk("full_order", 32'(bad), 32'd0);
        chk("full_done", 32'(done), 32'd1);
        chk("full_err", 32'(err), 32'd0);
        pulse_reload();

        // Bad checksum: correct value is 0x44, send 0x45
        base = wr_count;
        send_byte(8'h02);
        send_word(32'h11223344);
        send_word(32'hA5A55A5A);
        send_byte(8'h45);
        chk("badcs_wr_count", 32'(wr_count - base), 32'd2);
        chk("badcs_data1", log_data[base + 1], 32'hA5A55A5A);
        chk("badcs_addr1", 32'(log_addr[base + 1]), 32'd1);
        chk("badcs_err", 32'(err), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        chk("badcs_core_reset", 32'(core_reset), 32'd1);
        chk("badcs_in_ready", 32'(bus.in_ready), 32'd0);
        pulse_reload();
        chk("reload_err", 32'(err), 32'd0);
        chk("reload_err_in_ready", 32'(bus.in_ready), 32'd1);

        // Illegal counts
        base = wr_count;
        send_byte(8'h00);
        chk("cnt0_err", 32'(err), 32'd1);
        idle(3);
        pulse_reload();
        send_byte(8'h41);
        chk("cnt65_err", 32'(err), 32'd1);
        idle(3);
        chk("illegal_no_writes", 32'(wr_count - base), 32'd0);
        pulse_reload();

        // Gapped stream, reload pulse in DATA ignored; checksum 0x22^0x01^0x80 = 0xA3
        base = wr_count;
        send_byte(8'h03);
        for (int k = 0; k < 4; k++) begin
            idle($urandom_range(0, 3));
            send_byte(8'(32'hDEADBEEF >> (8 * k)));
        end
        pulse_reload();
        for (int k = 0; k < 4; k++) begin
            idle($urandom_range(0, 3));
            send_byte(8'(32'h00000001 >> (8 * k)));
        end
        for (int k = 0; k < 4; k++) begin
            idle($urandom_range(0, 3));
            send_byte(8'(32'h80000000 >> (8 * k)));
        end
        idle(2);
        send_byte(8'hA3);
        chk("gap_wr_count", 32'(wr_count - base), 32'd3);
        chk("gap_data0", log_data[base], 32'hDEADBEEF);
        chk("gap_data1", log_data[base + 1], 32'h00000001);
        chk("gap_data2", log_data[base + 2], 32'h80000000);
        chk("gap_addr2", 32'(log_addr[base + 2]), 32'd2);
        chk("gap_done", 32'(done), 32'd1);
        pulse_reload();

        // Reset after 6 payload bytes of a 2-word load
        base = wr_count;
        send_byte(8'h02);
        for (int k = 1; k <= 6; k++) send_byte(8'(k));
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(8);
        chk("midrst_writes", 32'(wr_count - base), 32'd1);
        chk("midrst_data0", log_data[base], 32'h04030201);
        chk("midrst_core_reset", 32'(core_reset), 32'd1);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);

        // Fresh load after reset; checksum 0x78^0x56^0x34^0x12 = 0x08
        base = wr_count;
        send_byte(8'h01);
        send_word(32'h12345678);
        send_byte(8'h08);
        chk("after_rst_writes", 32'(wr_count - base), 32'd1);
        chk("after_rst_addr", 32'(log_addr[base]), 32'd0);
        chk("after_rst_data", log_data[base], 32'h12345678);
        chk("after_rst_done", 32'(done), 32'd1);
        chk("after_rst_core_reset", 32'(core_reset), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
